// File: rtl/rvga_ddr_arbiter_if.sv
// rtl/rvga_ddr_arbiter_if.sv - bus bundle between the two L1 cache miss ports and the shared DDR port
//
// Purpose: groups every cache-side and DDR-side signal of the arbiter.
// Modports:
//   slave  - arbiter view: cache requests, DDR read data and DDR response in; cache responses, DDR command and arb_timeout out
//   master - environment view: the same signals with opposite directions
interface rvga_ddr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] icache_iddr_addr;
  logic              icache_iddr_read;
  logic [LINE_W-1:0] iddr_icache_rdata;
  logic              iddr_icache_resp;

  logic [ADDR_W-1:0] dcache_dddr_addr;
  logic              dcache_dddr_read;
  logic              dcache_dddr_write;
  logic [LINE_W-1:0] dcache_dddr_wdata;
  logic [LINE_W-1:0] dddr_dcache_rdata;
  logic              dddr_dcache_resp;

  logic [ADDR_W-1:0] ddr_addr;
  logic              ddr_read;
  logic              ddr_write;
  logic [LINE_W-1:0] ddr_wdata;
  logic [LINE_W-1:0] ddr_rdata;
  logic              ddr_resp;

  logic              arb_timeout;

  modport slave (
    input  icache_iddr_addr, icache_iddr_read,
    output iddr_icache_rdata, iddr_icache_resp,
    input  dcache_dddr_addr, dcache_dddr_read, dcache_dddr_write, dcache_dddr_wdata,
    output dddr_dcache_rdata, dddr_dcache_resp,
    output ddr_addr, ddr_read, ddr_write, ddr_wdata,
    input  ddr_rdata, ddr_resp,
    output arb_timeout
  );

  modport master (
    output icache_iddr_addr, icache_iddr_read,
    input  iddr_icache_rdata, iddr_icache_resp,
    output dcache_dddr_addr, dcache_dddr_read, dcache_dddr_write, dcache_dddr_wdata,
    input  dddr_dcache_rdata, dddr_dcache_resp,
    input  ddr_addr, ddr_read, ddr_write, ddr_wdata,
    output ddr_rdata, ddr_resp,
    input  arb_timeout
  );
endinterface

// File: rtl/rvga_ddr_arbiter.sv
// rtl/rvga_ddr_arbiter.sv - round-robin arbiter sharing one DDR port between I-cache and D-cache
//
// Purpose: grants one cache miss at a time onto the shared DDR port, returns the
// line and a one-cycle resp pulse to the granted cache, then idles for one cycle.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - rvga_ddr_arbiter_if.slave: cache request/response pairs, DDR command/response, arb_timeout
module rvga_ddr_arbiter #(
  parameter int          ADDR_W      = 32,
  parameter int          LINE_W      = 256,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  rvga_ddr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // 1 = D-cache holds the most recent grant, so I-cache wins the next tie.
  logic        last_grant_d;
  logic [31:0] timer;
  logic [31:0] timer_inc;

  logic              ireq;
  logic              dreq;
  logic [ADDR_W-1:0] grant_addr;
  logic [LINE_W-1:0] grant_wdata;
  logic              grant_write;

  assign ireq      = bus.icache_iddr_read;
  assign dreq      = bus.dcache_dddr_read | bus.dcache_dddr_write;
  assign timer_inc = timer + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_addr  = '0;
    grant_wdata = '0;
    grant_write = 1'b0;
    case (state)
      IDLE: begin
        if (ireq && (!dreq || last_grant_d)) begin
          state_next = SERVE_I;
          grant_addr = bus.icache_iddr_addr;
        end else if (dreq) begin
          state_next  = SERVE_D;
          grant_addr  = bus.dcache_dddr_addr;
          grant_wdata = bus.dcache_dddr_wdata;
          // Read+write together is illegal; the writeback wins.
          grant_write = bus.dcache_dddr_write;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.ddr_resp) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Requests are ignored here so a requester still holding its
        // request after resp cannot be granted twice.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ddr_addr          <= '0;
      bus.ddr_read          <= 1'b0;
      bus.ddr_write         <= 1'b0;
      bus.ddr_wdata         <= '0;
      bus.iddr_icache_rdata <= '0;
      bus.iddr_icache_resp  <= 1'b0;
      bus.dddr_dcache_rdata <= '0;
      bus.dddr_dcache_resp  <= 1'b0;
      bus.arb_timeout       <= 1'b0;
      last_grant_d          <= 1'b1;
      timer                 <= '0;
    end else begin
      bus.iddr_icache_resp <= 1'b0;
      bus.dddr_dcache_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (state_next != IDLE) begin
            bus.ddr_addr  <= grant_addr;
            bus.ddr_wdata <= grant_wdata;
            bus.ddr_write <= grant_write;
            bus.ddr_read  <= ~grant_write;
            last_grant_d  <= (state_next == SERVE_D);
            timer         <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (timer != TIMEOUT_CYC) begin
            timer <= timer_inc;
          end
          // Sticky: the FSM keeps waiting, only rst clears the flag.
          if ((TIMEOUT_CYC != 0) && (timer_inc == TIMEOUT_CYC)) begin
            bus.arb_timeout <= 1'b1;
          end
          if (bus.ddr_resp) begin
            bus.ddr_read  <= 1'b0;
            bus.ddr_write <= 1'b0;
            if (state == SERVE_I) begin
              bus.iddr_icache_rdata <= bus.ddr_rdata;
              bus.iddr_icache_resp  <= 1'b1;
            end else begin
              bus.dddr_dcache_rdata <= bus.ddr_rdata;
              bus.dddr_dcache_resp  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
